// File: rtl/rd_cpl_rx_pkg.sv
// Shared definitions for the read-completion receive path: TLP header codes,
// FSM state type and the DW byte-order helper shared with the tx side.
package rd_cpl_rx_pkg;

  localparam logic [6:0] CPLD_FMT_TYPE = 7'b10_01010;
  localparam logic [2:0] CPL_SC        = 3'b000;
  localparam logic [7:0] RREM_UPPER_DW = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR2,
    ST_DATA,
    ST_DROP
  } rx_state_t;

  function automatic logic [31:0] dw_endian_conv(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // A completion is the last one of its request when the bytes still owed
  // equal the bytes it carries; zero encodes the maximum in both fields.
  function automatic logic cpl_is_last(input logic [11:0] byte_count,
                                       input logic [9:0]  length);
    logic [12:0] bc_bytes;
    logic [12:0] len_bytes;
    bc_bytes  = (byte_count == 12'd0) ? 13'd4096 : {1'b0, byte_count};
    len_bytes = (length == 10'd0) ? 13'd4096 : {1'b0, length, 2'b00};
    return bc_bytes == len_bytes;
  endfunction

endpackage

// File: rtl/rd_cpl_rx_tag_ofs.sv
// Per-tag QW write offset table: cleared when a read is issued on a tag,
// bumped on every payload write, read combinationally by the current tag.
module cpl_tag_ofs #(
  parameter int OSRW = 4,
  parameter int SLTW = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_en,
  input  logic [OSRW-1:0] clr_tag,
  input  logic            inc_en,
  input  logic [OSRW-1:0] inc_tag,
  input  logic [OSRW-1:0] rd_tag,
  output logic [SLTW-1:0] rd_ofs
);

  logic [SLTW-1:0] ofs [2**OSRW];

  // A clear on the same tag as an increment wins so a re-issued read starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**OSRW; i++) begin
        ofs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2**OSRW; i++) begin
        if (clr_en && clr_tag == OSRW'(i)) begin
          ofs[i] <= '0;
        end else if (inc_en && inc_tag == OSRW'(i)) begin
          ofs[i] <= ofs[i] + SLTW'(1);
        end
      end
    end
  end

  assign rd_ofs = ofs[rd_tag];

endmodule

// File: rtl/rd_cpl_rx.sv
// Receive side of host-memory reads: parses CplD TLPs from the TRN rx port,
// realigns the 3DW-header payload to QWs and writes them to per-tag buffer slots.
module rd_cpl_rx
  import rd_cpl_rx_pkg::*;
#(
  parameter logic [4:0] RQTB = 5'b00000,
  parameter int         OSRW = 4,
  parameter int         SLTW = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          trn_rd,
  input  logic [7:0]           trn_rrem_n,
  input  logic                 trn_rsof_n,
  input  logic                 trn_reof_n,
  input  logic                 trn_rsrc_rdy_n,
  output logic                 trn_rdst_rdy_n,
  input  logic                 buf_rdy,
  input  logic                 rd_issue,
  input  logic [OSRW-1:0]      rd_issue_tag,
  output logic                 wr_en,
  output logic [OSRW+SLTW-1:0] wr_addr,
  output logic [63:0]          wr_data,
  output logic                 cpl_done,
  output logic [OSRW-1:0]      cpl_done_tag,
  output logic                 cpl_err
);

  localparam logic [7-OSRW:0] TAG_PFX = {3'b000, RQTB[4:OSRW]};

  rx_state_t       state;
  logic [6:0]      hdr_fmt_type;
  logic [9:0]      hdr_len;
  logic [2:0]      hdr_status;
  logic            hdr_last;
  logic [OSRW-1:0] cur_tag;
  logic [31:0]     held_low;
  logic            done_pend;
  logic [OSRW-1:0] done_tag;
  logic [SLTW-1:0] cur_ofs;

  logic            beat_ok;
  logic [7:0]      rx_tag;
  logic            is_cpld;
  logic            tag_match;
  logic            cpl_good;
  logic            ofs_inc;

  assign beat_ok   = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
  assign rx_tag    = trn_rd[47:40];
  assign is_cpld   = hdr_fmt_type == CPLD_FMT_TYPE;
  assign tag_match = rx_tag[7:OSRW] == TAG_PFX;
  assign cpl_good  = is_cpld && tag_match && hdr_status == CPL_SC && !hdr_len[0];
  assign ofs_inc   = beat_ok && state == ST_DATA;

  cpl_tag_ofs #(
    .OSRW(OSRW),
    .SLTW(SLTW)
  ) u_tag_ofs (
    .clk    (clk),
    .rst    (rst),
    .clr_en (rd_issue),
    .clr_tag(rd_issue_tag),
    .inc_en (ofs_inc),
    .inc_tag(cur_tag),
    .rd_tag (cur_tag),
    .rd_ofs (cur_ofs)
  );

  // Each data beat carries the upper DW of the current QW plus the lower DW
  // of the next one, so the lower half is held over a beat before writing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      trn_rdst_rdy_n <= 1'b1;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      cpl_done       <= 1'b0;
      cpl_done_tag   <= '0;
      cpl_err        <= 1'b0;
      hdr_fmt_type   <= '0;
      hdr_len        <= '0;
      hdr_status     <= '0;
      hdr_last       <= 1'b0;
      cur_tag        <= '0;
      held_low       <= '0;
      done_pend      <= 1'b0;
      done_tag       <= '0;
    end else begin
      trn_rdst_rdy_n <= !buf_rdy;
      wr_en          <= 1'b0;
      cpl_err        <= 1'b0;
      cpl_done       <= done_pend;
      done_pend      <= 1'b0;
      if (done_pend) begin
        cpl_done_tag <= done_tag;
      end
      if (beat_ok) begin
        unique case (state)
          ST_IDLE: begin
            if (!trn_rsof_n) begin
              hdr_fmt_type <= trn_rd[62:56];
              hdr_len      <= trn_rd[41:32];
              hdr_status   <= trn_rd[15:13];
              hdr_last     <= cpl_is_last(trn_rd[11:0], trn_rd[41:32]);
              if (trn_reof_n) begin
                state <= ST_HDR2;
              end
            end
          end
          ST_HDR2: begin
            cur_tag  <= rx_tag[OSRW-1:0];
            held_low <= trn_rd[31:0];
            if (!trn_reof_n) begin
              state   <= ST_IDLE;
              cpl_err <= is_cpld && tag_match;
            end else if (cpl_good) begin
              state <= ST_DATA;
            end else begin
              state   <= ST_DROP;
              cpl_err <= is_cpld && tag_match;
            end
          end
          ST_DATA: begin
            wr_en    <= 1'b1;
            wr_addr  <= {cur_tag, cur_ofs};
            wr_data  <= {dw_endian_conv(trn_rd[63:32]), dw_endian_conv(held_low)};
            held_low <= trn_rd[31:0];
            if (!trn_reof_n) begin
              state <= ST_IDLE;
              // An even-length payload must end on a half-filled beat.
              if (trn_rrem_n == RREM_UPPER_DW) begin
                done_pend <= hdr_last;
                done_tag  <= cur_tag;
              end else begin
                cpl_err <= 1'b1;
              end
            end
          end
          ST_DROP: begin
            if (!trn_reof_n) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rd_cpl_rx.sv
// Directed bench for rd_cpl_rx: drives CplD/MemWr TLPs on the TRN rx port and
// compares captured buffer writes, cpl_done and cpl_err against hand-built expectations.
module tb_rd_cpl_rx;

  localparam int OSRW = 4;
  localparam int SLTW = 9;
  localparam logic [6:0] FT_CPLD  = 7'b10_01010;
  localparam logic [6:0] FT_MEMWR = 7'b10_00000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [63:0]          trn_rd;
  logic [7:0]           trn_rrem_n;
  logic                 trn_rsof_n;
  logic                 trn_reof_n;
  logic                 trn_rsrc_rdy_n;
  logic                 trn_rdst_rdy_n;
  logic                 buf_rdy;
  logic                 rd_issue;
  logic [OSRW-1:0]      rd_issue_tag;
  logic                 wr_en;
  logic [OSRW+SLTW-1:0] wr_addr;
  logic [63:0]          wr_data;
  logic                 cpl_done;
  logic [OSRW-1:0]      cpl_done_tag;
  logic                 cpl_err;

  rd_cpl_rx #(
    .RQTB(5'b00000),
    .OSRW(OSRW),
    .SLTW(SLTW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trn_rd        (trn_rd),
    .trn_rrem_n    (trn_rrem_n),
    .trn_rsof_n    (trn_rsof_n),
    .trn_reof_n    (trn_reof_n),
    .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n),
    .buf_rdy       (buf_rdy),
    .rd_issue      (rd_issue),
    .rd_issue_tag  (rd_issue_tag),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .cpl_done      (cpl_done),
    .cpl_done_tag  (cpl_done_tag),
    .cpl_err       (cpl_err)
  );

  always #5 clk = ~clk;

  int checkCnt = 0;
  int failCnt  = 0;
  int cycleCnt = 0;
  int lastWrCycle = 0;
  int errCnt = 0;
  int stallCnt = 0;
  logic [63:0] wrAddrQ[$];
  logic [63:0] wrDataQ[$];
  int          doneTagQ[$];
  int          doneGapQ[$];
  logic [63:0] txData[$];
  logic        txSof[$];
  logic        txEof[$];
  logic [7:0]  txRrem[$];

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checkCnt++;
    if (observed !== expected) begin
      failCnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] d);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(3-b) +: 8];
    return r;
  endfunction

  // Output capture, sampled mid-cycle away from the active edge
  always @(negedge clk) begin
    cycleCnt++;
    if (wr_en) begin
      wrAddrQ.push_back(64'(wr_addr));
      wrDataQ.push_back(wr_data);
      lastWrCycle = cycleCnt;
    end
    if (cpl_done) begin
      doneTagQ.push_back(int'(cpl_done_tag));
      doneGapQ.push_back(cycleCnt - lastWrCycle);
    end
    if (cpl_err) errCnt++;
    if (trn_rdst_rdy_n) stallCnt++;
  end

  task automatic clearObs();
    @(negedge clk);
    #1;
    wrAddrQ.delete();
    wrDataQ.delete();
    doneTagQ.delete();
    doneGapQ.delete();
    errCnt = 0;
    stallCnt = 0;
  endtask

  task automatic clearTx();
    txData.delete();
    txSof.delete();
    txEof.delete();
    txRrem.delete();
  endtask

  function automatic logic [31:0] cplDw2(input logic [7:0] tag);
    return {16'h0000, tag, 8'h00};
  endfunction

  task automatic buildTlp(input logic [6:0] ft, input logic [9:0] len, input logic [11:0] bc,
                          input logic [2:0] st, input logic [31:0] dw2, input logic [31:0] base);
    logic [31:0] dws[$];
    int nPay;
    nPay = (len == 10'd0) ? 1024 : int'(len);
    dws.push_back({1'b0, ft, 14'd0, len});
    dws.push_back({16'h0100, st, 1'b0, bc});
    dws.push_back(dw2);
    for (int i = 0; i < nPay; i++) dws.push_back(base + 32'(i));
    for (int i = 0; i < dws.size(); i += 2) begin
      logic [31:0] lo;
      lo = (i + 1 < dws.size()) ? dws[i+1] : 32'h0;
      txData.push_back({dws[i], lo});
      txSof.push_back(i == 0);
      txEof.push_back(i + 2 >= dws.size());
      txRrem.push_back((i + 1 < dws.size()) ? 8'h00 : 8'h0F);
    end
  endtask

  task automatic applyStimulus(input int idx);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    trn_rd         = txData[idx];
    trn_rsof_n     = !txSof[idx];
    trn_reof_n     = !txEof[idx];
    trn_rrem_n     = txRrem[idx];
    trn_rsrc_rdy_n = 1'b0;
    while (trn_rdst_rdy_n && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (waitCycles >= 20) checkOutput("beat_accept_timeout", 64'(waitCycles), 64'd0);
    @(posedge clk);
  endtask

  task automatic goIdle();
    @(negedge clk);
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
  endtask

  task automatic sendRange(input int first, input int last);
    for (int i = first; i <= last; i++) applyStimulus(i);
    goIdle();
    repeat (4) @(negedge clk);
  endtask

  task automatic sendTlp(input logic [6:0] ft, input logic [9:0] len, input logic [11:0] bc,
                         input logic [2:0] st, input logic [31:0] dw2, input logic [31:0] base);
    clearTx();
    buildTlp(ft, len, bc, st, dw2, base);
    sendRange(0, txData.size() - 1);
  endtask

  task automatic issueRead(input int tag);
    @(negedge clk);
    rd_issue     = 1'b1;
    rd_issue_tag = OSRW'(tag);
    @(negedge clk);
    rd_issue     = 1'b0;
  endtask

  task automatic checkCpl(input string name, input int tag, input int startOff, input int nQw,
                          input logic [31:0] base, input int expDone, input int expErr);
    checkOutput({name, "_wr_count"}, 64'(wrAddrQ.size()), 64'(nQw));
    for (int k = 0; k < nQw && k < wrAddrQ.size(); k++) begin
      checkOutput({name, "_addr"}, wrAddrQ[k], 64'(tag * 512 + (startOff + k) % 512));
      checkOutput({name, "_data"}, wrDataQ[k],
                  {bswap(base + 32'(2*k + 1)), bswap(base + 32'(2*k))});
    end
    checkOutput({name, "_done_count"}, 64'(doneTagQ.size()), 64'(expDone));
    if (expDone > 0 && doneTagQ.size() > 0) begin
      checkOutput({name, "_done_tag"}, 64'(doneTagQ[0]), 64'(tag));
      checkOutput({name, "_done_gap"}, 64'(doneGapQ[0]), 64'd1);
    end
    checkOutput({name, "_err_count"}, 64'(errCnt), 64'(expErr));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    trn_rd         = '0;
    trn_rrem_n     = '0;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    buf_rdy        = 1'b1;
    rd_issue       = 1'b0;
    rd_issue_tag   = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_rdst_rdy_n", 64'(trn_rdst_rdy_n), 64'd1);
    checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
    checkOutput("rst_wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("rst_wr_data", wr_data, 64'd0);
    checkOutput("rst_cpl_done", 64'(cpl_done), 64'd0);
    checkOutput("rst_cpl_done_tag", 64'(cpl_done_tag), 64'd0);
    checkOutput("rst_cpl_err", 64'(cpl_err), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rdst_rdy_after_rst", 64'(trn_rdst_rdy_n), 64'd0);

    $display("[TB] 8-QW completion on tag 3");
    clearObs();
    sendTlp(FT_CPLD, 10'd16, 12'd64, 3'b000, cplDw2(8'h03), 32'h0);
    checkOutput("cpl8_first_addr", (wrAddrQ.size() > 0) ? wrAddrQ[0] : '1, 64'd1536);
    checkOutput("cpl8_first_data", (wrDataQ.size() > 0) ? wrDataQ[0] : '1, 64'h01000000_00000000);
    checkCpl("cpl8", 3, 0, 8, 32'h0, 1, 0);

    $display("[TB] 32-QW read split into two back-to-back completions on tag 1");
    clearObs();
    clearTx();
    buildTlp(FT_CPLD, 10'd32, 12'd256, 3'b000, cplDw2(8'h01), 32'd0);
    buildTlp(FT_CPLD, 10'd32, 12'd128, 3'b000, cplDw2(8'h01), 32'd32);
    sendRange(0, txData.size() - 1);
    checkCpl("split", 1, 0, 32, 32'd0, 1, 0);

    $display("[TB] UR completion on tag 2");
    clearObs();
    sendTlp(FT_CPLD, 10'd4, 12'd16, 3'b001, cplDw2(8'h02), 32'h600);
    checkCpl("ur", 2, 0, 0, 32'h0, 0, 1);

    $display("[TB] MemWr followed by completion with foreign tag prefix");
    clearObs();
    clearTx();
    buildTlp(FT_MEMWR, 10'd2, 12'd0, 3'b000, 32'h1000_0000, 32'h700);
    buildTlp(FT_CPLD, 10'd4, 12'd16, 3'b000, cplDw2(8'h13), 32'h710);
    sendRange(0, txData.size() - 1);
    checkCpl("foreign", 0, 0, 0, 32'h0, 0, 0);

    $display("[TB] odd-length completion on tag 4");
    clearObs();
    sendTlp(FT_CPLD, 10'd3, 12'd12, 3'b000, cplDw2(8'h04), 32'h800);
    checkCpl("odd", 4, 0, 0, 32'h0, 0, 1);

    $display("[TB] buffer backpressure mid-payload on tag 6");
    clearObs();
    fork
      begin
        repeat (5) @(negedge clk);
        buf_rdy = 1'b0;
        repeat (3) @(negedge clk);
        buf_rdy = 1'b1;
      end
    join_none
    sendTlp(FT_CPLD, 10'd16, 12'd64, 3'b000, cplDw2(8'h06), 32'h100);
    checkOutput("stall_cycles", 64'(stallCnt), 64'd3);
    checkCpl("stall", 6, 0, 8, 32'h100, 1, 0);

    $display("[TB] offset clear and wrap on tag 5");
    clearObs();
    sendTlp(FT_CPLD, 10'd14, 12'd400, 3'b000, cplDw2(8'h05), 32'h200);
    checkCpl("t5_pre", 5, 0, 7, 32'h200, 0, 0);
    issueRead(5);
    clearObs();
    sendTlp(FT_CPLD, 10'd2, 12'd8, 3'b000, cplDw2(8'h05), 32'h300);
    checkCpl("t5_clr", 5, 0, 1, 32'h300, 1, 0);
    issueRead(5);
    clearObs();
    sendTlp(FT_CPLD, 10'd0, 12'd0, 3'b000, cplDw2(8'h05), 32'h1000);
    checkCpl("t5_1k", 5, 0, 512, 32'h1000, 1, 0);
    clearObs();
    sendTlp(FT_CPLD, 10'd2, 12'd8, 3'b000, cplDw2(8'h05), 32'h2000);
    checkCpl("t5_wrap", 5, 0, 1, 32'h2000, 1, 0);

    $display("[TB] reset in the middle of a completion on tag 7");
    clearTx();
    buildTlp(FT_CPLD, 10'd16, 12'd64, 3'b000, cplDw2(8'h07), 32'h500);
    for (int i = 0; i < 4; i++) applyStimulus(i);
    goIdle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clearObs();
    sendRange(4, txData.size() - 1);
    checkCpl("rst_tail", 7, 0, 0, 32'h0, 0, 0);
    clearObs();
    sendTlp(FT_CPLD, 10'd2, 12'd8, 3'b000, cplDw2(8'h03), 32'h900);
    checkCpl("post_rst", 3, 0, 1, 32'h900, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
    $finish;
  end

endmodule
